// File: rtl/fp_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and the
// helper that turns a mux-level count into a pipeline-stage count.
package fp_shift_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    function automatic int num_stages(input int levels, input int per_stage);
        return (levels + per_stage - 1) / per_stage;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational rung of the barrel-shifter ladder: shifts by DIST when enabled
// and folds any bits dropped off the LSB end into the sticky flag for right shifts.
module shift_level
    import fp_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    input  logic             sign_i,
    input  logic             en_i,
    input  logic             sticky_i,
    output logic [WIDTH-1:0] data_o,
    output logic             sticky_o
);

    // Select the shifted word for the active mode; pass through when disabled.
    always_comb begin
        data_o   = data_i;
        sticky_o = sticky_i;
        if (en_i) begin
            case (mode_i)
                MODE_LSL: data_o = data_i << DIST;
                MODE_LSR: begin
                    data_o   = data_i >> DIST;
                    sticky_o = sticky_i | (|data_i[DIST-1:0]);
                end
                MODE_ASR: begin
                    data_o   = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
                    sticky_o = sticky_i | (|data_i[DIST-1:0]);
                end
                MODE_ROL: data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
                default: begin
                    data_o   = data_i;
                    sticky_o = sticky_i;
                end
            endcase
        end else begin
            data_o   = data_i;
            sticky_o = sticky_i;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log2 barrel shifter (LSL/LSR/ASR/ROL) with right-shift sticky, a
// valid/ready handshake and a register after every PIPE_EVERY mux levels.
module pipelined_barrel_shifter
    import fp_shift_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHW        = $clog2(WIDTH),
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic [TAG_W-1:0] out_tag
);

    localparam int           NSTG    = num_stages(SHW, PIPE_EVERY);
    localparam logic [SHW:0] WIDTH_C = (SHW + 1)'(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       mode;
        logic [SHW-1:0]   amt;
        logic             sticky;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic             stall_s;
    logic [SHW-1:0]   amt_adj_s;
    logic [NSTG-1:0]  valid_q;
    stage_t           stage_q    [NSTG];
    stage_t           stage_d    [NSTG];
    stage_t           src_s      [NSTG];
    logic [WIDTH-1:0] lvl_in_s   [SHW];
    logic [WIDTH-1:0] lvl_out_s  [SHW];
    logic             lvl_sin_s  [SHW];
    logic             lvl_sout_s [SHW];

    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;

    // Wrap an over-range rotate amount once so the ladder only rotates by < WIDTH.
    always_comb begin
        amt_adj_s = in_amt;
        if ((in_mode == MODE_ROL) && ({1'b0, in_amt} >= WIDTH_C)) begin
            amt_adj_s = in_amt - WIDTH_C[SHW-1:0];
        end else begin
            amt_adj_s = in_amt;
        end
    end

    assign src_s[0] = '{data: in_data, mode: in_mode, amt: amt_adj_s, sticky: 1'b0, tag: in_tag};

    for (genvar s = 1; s < NSTG; s++) begin : g_src
        assign src_s[s] = stage_q[s-1];
    end

    // The MSB stays equal to the original sign bit throughout an ASR, so it doubles as fill.
    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        localparam int S = k / PIPE_EVERY;
        if (k % PIPE_EVERY == 0) begin : g_head
            assign lvl_in_s[k]  = src_s[S].data;
            assign lvl_sin_s[k] = src_s[S].sticky;
        end else begin : g_chain
            assign lvl_in_s[k]  = lvl_out_s[k-1];
            assign lvl_sin_s[k] = lvl_sout_s[k-1];
        end
        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .data_i   (lvl_in_s[k]),
            .mode_i   (src_s[S].mode),
            .sign_i   (lvl_in_s[k][WIDTH-1]),
            .en_i     (src_s[S].amt[k]),
            .sticky_i (lvl_sin_s[k]),
            .data_o   (lvl_out_s[k]),
            .sticky_o (lvl_sout_s[k])
        );
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        localparam int LAST = ((s + 1) * PIPE_EVERY < SHW) ? (s + 1) * PIPE_EVERY - 1 : SHW - 1;
        assign stage_d[s] = '{data: lvl_out_s[LAST], mode: src_s[s].mode, amt: src_s[s].amt,
                              sticky: lvl_sout_s[LAST], tag: src_s[s].tag};
    end

    // Pipeline advance; every stage, bubbles included, freezes while the output stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < NSTG; s++) begin
                stage_q[s] <= '0;
            end
        end else if (!stall_s) begin
            valid_q[0] <= in_valid;
            stage_q[0] <= stage_d[0];
            for (int s = 1; s < NSTG; s++) begin
                valid_q[s] <= valid_q[s-1];
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign out_valid  = valid_q[NSTG-1];
    assign out_data   = stage_q[NSTG-1].data;
    assign out_sticky = stage_q[NSTG-1].sticky;
    assign out_tag    = stage_q[NSTG-1].tag;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter across three width/pipelining
// configurations, checked against a bit-level reference model.
module tb_pipelined_barrel_shifter;

    localparam int NCFG = 3;

    logic clk;
    int   tests    = 0;
    int   fails    = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 32 : ((g == 1) ? 25 : 48);
        localparam int SW = $clog2(W);
        localparam int P  = (g == 0) ? 2 : ((g == 1) ? 1 : SW);
        localparam int L  = (SW + P - 1) / P;

        typedef struct packed {
            logic [W-1:0] d;
            logic         s;
            logic [3:0]   t;
        } exp_t;

        logic          rst;
        logic          in_valid, in_ready, out_valid, out_ready, out_sticky;
        logic [W-1:0]  in_data, out_data;
        logic [SW-1:0] in_amt;
        logic [1:0]    in_mode;
        logic [3:0]    in_tag, out_tag;
        logic          rnd_ready;
        logic          saw_stall;
        int            cyc;
        int            bp_lo;
        int            bp_hi;
        exp_t          exp_q [$];

        pipelined_barrel_shifter #(
            .WIDTH      (W),
            .PIPE_EVERY (P),
            .TAG_W      (4)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_data    (in_data),
            .in_amt     (in_amt),
            .in_mode    (in_mode),
            .in_tag     (in_tag),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_data   (out_data),
            .out_sticky (out_sticky),
            .out_tag    (out_tag)
        );

        // Bit-by-bit definition: each result bit is taken from its source position or fill.
        function automatic exp_t model(input logic [W-1:0] d, input int amt,
                                       input logic [1:0] m, input logic [3:0] t);
            exp_t e;
            int   src;
            e.d = '0;
            e.s = 1'b0;
            e.t = t;
            for (int i = 0; i < W; i++) begin
                case (m)
                    2'b00: begin src = i - amt; e.d[i] = (src >= 0) ? d[src] : 1'b0; end
                    2'b01: begin src = i + amt; e.d[i] = (src < W) ? d[src] : 1'b0; end
                    2'b10: begin src = i + amt; e.d[i] = (src < W) ? d[src] : d[W-1]; end
                    default: begin src = ((i - amt) % W + W) % W; e.d[i] = d[src]; end
                endcase
                if ((m == 2'b01 || m == 2'b10) && i < amt) e.s = e.s | d[i];
            end
            return e;
        endfunction

        task automatic send(input logic [63:0] d, input int amt, input logic [1:0] m,
                            input logic [3:0] t);
            logic [W-1:0]  dw;
            logic [SW-1:0] aw;
            logic          acc;
            int            n;
            dw = d[W-1:0];
            aw = amt[SW-1:0];
            in_data = dw; in_amt = aw; in_mode = m; in_tag = t; in_valid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 2000) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                n++;
            end
            if (acc) exp_q.push_back(model(dw, int'(aw), m, t));
            else chk($sformatf("c%0d accept_timeout", g), 1'b0, 1'b1);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic drain(input int limit);
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < limit) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("c%0d drain", g), exp_q.size(), 0);
        endtask

        task automatic lat_check();
            int n;
            n = 1;
            while (!out_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("c%0d latency", g), n, L);
        endtask

        // Output-side consumer: random, held high, or forced low inside a backpressure window.
        initial begin : ready_drv
            out_ready = 1'b1;
            cyc = 0;
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                if (cyc >= bp_lo && cyc <= bp_hi) out_ready = 1'b0;
                else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
                else out_ready = 1'b1;
            end
        end

        // Monitor: checks the ready relation each cycle and pops the scoreboard on every consume.
        initial begin : mon
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    chk($sformatf("c%0d in_ready", g), in_ready, !(out_valid && !out_ready));
                    if (!in_ready) saw_stall = 1'b1;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("c%0d unexpected_beat tag", g), out_tag, 5'h10);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("c%0d data tag%0d", g, e.t), out_data, e.d);
                            chk($sformatf("c%0d sticky tag%0d", g, e.t), out_sticky, e.s);
                            chk($sformatf("c%0d tag", g), out_tag, e.t);
                        end
                    end
                end
            end
        end

        initial begin : seq
            logic [63:0] dv [15];
            int          av [15];
            logic [1:0]  mv [15];
            dv = '{64'h2710, 64'h8000_0001, 64'h8000_0000, 64'h8000_0001, 64'd10006,
                   64'h100_0000, 64'h1FF_FFFF, 64'hFEDC_BA98_7654_3211, 64'hFEDC_BA98_7654_3211,
                   64'hFEDC_BA98_7654_3211, 64'hFEDC_BA98_7654_3211, 64'hFFFF_FFFF_FFFF_F001,
                   64'h1_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_8000_0040_0001};
            av = '{10, 1, 4, 4, 15, 27, 30, 0, 0, 0, 0, 29, 31, 17, 23};
            mv = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01,
                   2'b10, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
            rst = 1'b1; rnd_ready = 1'b0; saw_stall = 1'b0; bp_lo = -1; bp_hi = -2;
            in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = 2'b00; in_tag = 4'd0;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("c%0d rst out_valid", g), out_valid, 1'b0);
            chk($sformatf("c%0d rst out_data", g), out_data, '0);
            chk($sformatf("c%0d rst out_sticky", g), out_sticky, 1'b0);
            chk($sformatf("c%0d rst out_tag", g), out_tag, 4'd0);
            rst = 1'b0;
            #1;
            chk($sformatf("c%0d ready after rst", g), in_ready, 1'b1);

            send(dv[0], av[0], mv[0], 4'd0);
            lat_check();
            for (int i = 1; i < 15; i++) send(dv[i], av[i], mv[i], 4'(i));
            drain(200);

            saw_stall = 1'b0;
            bp_lo = cyc + 4;
            bp_hi = cyc + 8;
            for (int t = 0; t < 6; t++) begin
                send({$urandom, $urandom}, $urandom_range(0, (1 << SW) - 1),
                     2'($urandom_range(0, 3)), 4'(t));
            end
            drain(200);
            chk($sformatf("c%0d in_ready fell under stall", g), saw_stall, 1'b1);

            for (int t = 9; t < 12; t++) send(64'hFFFF_FFFF_FFFF_FFFF, 3, 2'b01, 4'(t));
            #2;
            rst = 1'b1;
            #1;
            chk($sformatf("c%0d midrst out_valid", g), out_valid, 1'b0);
            chk($sformatf("c%0d midrst out_data", g), out_data, '0);
            chk($sformatf("c%0d midrst out_sticky", g), out_sticky, 1'b0);
            chk($sformatf("c%0d midrst out_tag", g), out_tag, 4'd0);
            exp_q.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            chk($sformatf("c%0d ready after midrst", g), in_ready, 1'b1);
            send(64'h0000_0000_0F0F_1234, 5, 2'b10, 4'd7);
            lat_check();
            drain(200);

            rnd_ready = 1'b1;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send({$urandom, $urandom}, $urandom_range(0, (1 << SW) - 1),
                     2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            end
            drain(5000);
            done_cnt++;
        end
    end

    initial begin : finisher
        int n;
        n = 0;
        while (done_cnt < NCFG && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < NCFG) begin
            tests++;
            fails++;
            $display("FAIL watchdog: %0d of %0d configs finished", done_cnt, NCFG);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
